// File: rtl/inst_fetch_unit_pkg.sv
// inst_fetch_unit_pkg: shared widths, defaults, FSM states and fetch-queue entry type
package inst_fetch_unit_pkg;
    localparam int ADDR_LEN = 32;
    localparam int INSTR_LEN = 32;
    localparam int FQ_DEPTH_DEF = 4;
    localparam logic [ADDR_LEN-1:0] RESET_PC_DEF = 32'h0;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;
    typedef struct packed {
        logic [INSTR_LEN-1:0] inst;
        logic [ADDR_LEN-1:0]  pc_plus_4;
    } fq_entry_t;
    function automatic logic [ADDR_LEN-1:0] word_align(input logic [ADDR_LEN-1:0] a);
        return {a[ADDR_LEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// inst_fetch_unit_fetch_queue: synchronous FIFO with flush and occupancy count
module inst_fetch_unit_fetch_queue
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    output logic                   valid,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    fq_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign valid   = count != '0;
    assign do_pop  = pop && valid;
    assign do_push = push && (count < (AW+1)'(DEPTH) || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;
    // Pointer/count bookkeeping; flush empties the queue even when a pop completes alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // Entry storage; a write into the slot being popped is safe since the head is read before the edge
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: credit-based instruction fetch with in-order response queue and redirect draining
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int                  FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [ADDR_LEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req_valid,
    output logic [ADDR_LEN-1:0]  imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_resp_valid,
    input  logic [INSTR_LEN-1:0] imem_resp_inst,
    input  logic                 redirect_valid,
    input  logic [ADDR_LEN-1:0]  redirect_pc,
    output logic                 out_valid,
    output logic [INSTR_LEN-1:0] out_inst,
    output logic [ADDR_LEN-1:0]  out_pc_plus_4,
    input  logic                 out_ready
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;
    fetch_state_t state, state_nx;
    logic [ADDR_LEN-1:0] fetch_pc, resp_pc;
    logic [CW-1:0] inflight, inflight_nx, drop_cnt, drop_nx, fq_count;
    logic req_acc, keep_resp, credit_ok;
    fq_entry_t fq_in, fq_head;
    // inflight counts every issued-but-unanswered request; in RUN none are doomed, so it is the outstanding count
    assign credit_ok      = ({1'b0, inflight} + {1'b0, fq_count}) < (CW+1)'(FQ_DEPTH);
    assign imem_req_valid = state == ST_RUN && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_acc        = imem_req_valid && imem_req_ready;
    assign keep_resp      = imem_resp_valid && drop_cnt == '0 && !redirect_valid;
    assign inflight_nx    = inflight + CW'(req_acc) - CW'(imem_resp_valid);
    assign fq_in          = '{inst: imem_resp_inst, pc_plus_4: resp_pc + ADDR_LEN'(4)};
    assign out_inst       = fq_head.inst;
    assign out_pc_plus_4  = fq_head.pc_plus_4;
    // Next state and drop count: a redirect dooms everything still in flight, including this cycle's issue
    always_comb begin
        drop_nx  = redirect_valid ? inflight_nx : drop_cnt - CW'(imem_resp_valid && drop_cnt != '0);
        state_nx = state == ST_IDLE ? ST_RUN : state;
        if (redirect_valid) state_nx = inflight_nx != '0 ? ST_DRAIN : ST_RUN;
        else if (state == ST_DRAIN && drop_nx == '0) state_nx = ST_RUN;
    end
    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else state <= state_nx;
    end
    // Fetch/response PCs and in-flight bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= word_align(RESET_PC);
            resp_pc  <= word_align(RESET_PC);
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_nx;
            drop_cnt <= drop_nx;
            if (redirect_valid) begin
                fetch_pc <= word_align(redirect_pc);
                resp_pc  <= word_align(redirect_pc);
            end else begin
                if (req_acc) fetch_pc <= fetch_pc + ADDR_LEN'(4);
                if (keep_resp) resp_pc <= resp_pc + ADDR_LEN'(4);
            end
        end
    end
    inst_fetch_unit_fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data (fq_in),
        .pop       (out_ready),
        .valid     (out_valid),
        .head      (fq_head),
        .count     (fq_count)
    );
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: randomized fetch/redirect/stall stimulus checked against a program-order model
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;
    localparam int D = 4;
    localparam logic [31:0] RPC = 32'h0;
    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } mreq_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid, out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_resp_inst, redirect_pc, out_inst, out_pc_plus_4;
    mreq_t memq[$];
    logic [31:0] hs_log[$];
    logic [31:0] exp_req_pc, exp_out_pc;
    int total = 0, bad = 0, cyc = 0, ep = 0, occ = 0, n_acc = 0;
    bit started = 0;
    int lat_lo = 1, lat_hi = 1, rdy_pct = 100, ord_pct = 100, rsp_pct = 100, rdr_pm = 0;
    always #5 clk = ~clk;
    inst_fetch_unit #(.FQ_DEPTH(D), .RESET_PC(RPC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_inst  (imem_resp_inst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_inst        (out_inst),
        .out_pc_plus_4   (out_pc_plus_4),
        .out_ready       (out_ready)
    );
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C ^ {a[7:0], a[31:8]};
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    // one clock: drive at negedge, check just after, update the model at the posedge
    task automatic step(input bit frc, input logic [31:0] fpc);
        int old_n, kept_n, d;
        bit exp_rv, acc, hs, rsp;
        logic [31:0] a, pc4;
        mreq_t r;
        @(negedge clk);
        imem_req_ready = $urandom_range(99) < rdy_pct;
        out_ready = $urandom_range(99) < ord_pct;
        redirect_valid = frc || (started && $urandom_range(999) < rdr_pm);
        redirect_pc = frc ? fpc : ($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                                          : ($urandom() & 32'h0000_FFFC));
        if (memq.size() > 0 && memq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst = inst_of(memq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst = $urandom();
        end
        #1;
        old_n = 0;
        foreach (memq[i]) if (memq[i].ep != ep) old_n++;
        kept_n = memq.size() - old_n;
        exp_rv = started && !redirect_valid && old_n == 0 && kept_n + occ < D;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req_pc);
        chk("out_valid", 32'(out_valid), 32'(occ > 0));
        if (occ > 0) begin
            chk("out_pc4", out_pc_plus_4, exp_out_pc + 32'd4);
            chk("out_inst", out_inst, inst_of(exp_out_pc));
        end
        a = imem_req_addr;
        pc4 = out_pc_plus_4;
        acc = imem_req_valid && imem_req_ready;
        hs = out_valid && out_ready;
        rsp = imem_resp_valid;
        @(posedge clk);
        cyc++;
        if (rsp) begin
            r = memq.pop_front();
            if (r.ep == ep && !redirect_valid) occ++;
        end
        if (acc) begin
            d = cyc + int'($urandom_range(lat_hi, lat_lo)) - 1;
            memq.push_back('{addr: a, ep: ep, due: d});
            n_acc++;
            exp_req_pc += 32'd4;
        end
        if (hs && occ > 0) begin
            occ--;
            exp_out_pc += 32'd4;
            hs_log.push_back(pc4);
        end
        if (redirect_valid) begin
            occ = 0;
            ep++;
            exp_req_pc = redirect_pc & ~32'd3;
            exp_out_pc = redirect_pc & ~32'd3;
        end
        started = 1;
    endtask
    // asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        imem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        out_ready = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pc4", out_pc_plus_4, 32'd0);
        memq.delete();
        hs_log.delete();
        occ = 0;
        ep = 0;
        started = 0;
        exp_req_pc = RPC;
        exp_out_pc = RPC;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("idle_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        started = 1;
    endtask
    task automatic knobs(input int llo, input int lhi, input int rdy, input int ord, input int rsp, input int rdr);
        lat_lo = llo; lat_hi = lhi; rdy_pct = rdy; ord_pct = ord; rsp_pct = rsp; rdr_pm = rdr;
    endtask
    initial begin
        logic [31:0] g;
        int n0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_inst = 0;
        redirect_valid = 0; redirect_pc = 0; out_ready = 0;
        // steady stream with single-cycle memory
        knobs(1, 1, 100, 100, 100, 0);
        do_reset();
        repeat (20) step(0, 0);
        chk("stream_count", hs_log.size(), 32'd18);
        for (int i = 0; i < 3; i++) begin
            g = hs_log.size() > i ? hs_log[i] : 32'hDEAD_BEEF;
            chk("stream_pc4", g, 32'(4 * (i + 1)));
        end
        // decode stall fills the queue, then drains in order
        do_reset();
        knobs(1, 1, 100, 0, 100, 0);
        n_acc = 0;
        repeat (10) step(0, 0);
        chk("stall_reqs", n_acc, 32'd4);
        ord_pct = 100;
        repeat (10) step(0, 0);
        for (int i = 0; i < 4; i++) begin
            g = hs_log.size() > i ? hs_log[i] : 32'hDEAD_BEEF;
            chk("stall_order", g, 32'(4 * (i + 1)));
        end
        // redirect with three requests in flight at three-cycle latency
        do_reset();
        knobs(3, 3, 100, 100, 100, 0);
        for (int i = 0; i < 20 && memq.size() < 3; i++) step(0, 0);
        chk("inflight_3", memq.size(), 32'd3);
        step(1, 32'h100);
        hs_log.delete();
        for (int i = 0; i < 30 && hs_log.size() == 0; i++) step(0, 0);
        g = hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF;
        chk("drain_first_pc4", g, 32'h104);
        // redirect coinciding with response and out handshake
        do_reset();
        knobs(1, 1, 100, 100, 100, 0);
        repeat (6) step(0, 0);
        n0 = hs_log.size();
        step(1, 32'h200);
        chk("rdr_hs_once", hs_log.size() - n0, 32'd1);
        step(0, 0);
        // address wrap at the top of memory
        step(1, 32'hFFFF_FFFC);
        hs_log.delete();
        for (int i = 0; i < 20 && hs_log.size() < 2; i++) step(0, 0);
        g = hs_log.size() > 0 ? hs_log[0] : 32'hDEAD_BEEF;
        chk("wrap_pc4_0", g, 32'h0);
        g = hs_log.size() > 1 ? hs_log[1] : 32'hDEAD_BEEF;
        chk("wrap_pc4_1", g, 32'h4);
        // reset while requests are outstanding
        knobs(3, 3, 100, 100, 100, 0);
        repeat (4) step(0, 0);
        chk("inflight_pre_rst", 32'(memq.size() >= 2), 32'd1);
        do_reset();
        knobs(1, 1, 100, 100, 100, 0);
        repeat (4) step(0, 0);
        // randomized traffic with an asynchronous reset in the middle
        knobs(1, 4, 70, 60, 80, 30);
        repeat (1500) step(0, 0);
        do_reset();
        knobs(1, 3, 85, 75, 90, 50);
        repeat (1500) step(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous assertion, active-low (0 = reset).
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  `ADDR_LEN  word address of request (bits [1:0] always 0).
REQ-007 imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 imem_resp_valid  input  1  instruction returned (in order, one per accepted request, >=1 cycle after acceptance).
REQ-009 imem_resp_inst  input  `INSTR_LEN  returned instruction.
REQ-010 redirect_valid  input  1  branch/jump resolved; flush and refetch.
REQ-011 redirect_pc  input  `ADDR_LEN  new fetch address.
REQ-012 out_valid  output  1  instruction available to IF/ID register.
REQ-013 out_inst  output  `INSTR_LEN  instruction at queue head.
REQ-014 out_pc_plus_4  output  `ADDR_LEN  address of head instruction + 4.
REQ-015 out_ready  input  1  IF/ID accepts head (low = decode stall).

Function
REQ-016 Handshakes SHALL complete when valid && ready on a rising edge; out_valid, once high, SHALL hold with stable out_inst/out_pc_plus_4 until accepted or redirect.
REQ-017 States SHALL be IDLE, RUN, DRAIN; IDLE -> RUN unconditionally one cycle after reset release.
REQ-018 In RUN, imem_req_valid SHALL be high iff outstanding + occupancy < FQ_DEPTH and redirect_valid is low (credit rule; queue never overflows).
REQ-019 Accepted request SHALL increment fetch_pc by 4 (mod 2^32 wrap) and outstanding by 1.
REQ-020 Response SHALL push {imem_resp_inst, resp_pc + 4} into the queue, advance resp_pc by 4, decrement outstanding.
REQ-021 Queue SHALL be FIFO; push and pop in the same cycle SHALL be legal at any occupancy including full and empty-with-bypass-disabled (entry visible on out_* one cycle after push).
REQ-022 On redirect_valid (any state): queue flushed, fetch_pc and resp_pc <= redirect_pc, drop_cnt <= outstanding (+1 if a request is accepted that cycle, −1 if a response arrives that cycle), next state DRAIN if resulting drop_cnt > 0 else RUN.
REQ-023 In DRAIN, no requests SHALL issue; each response SHALL be discarded and decrement drop_cnt; at drop_cnt reaching 0 next state RUN.
REQ-024 Redirect coincident with out handshake: handshake completes; flush still applies to all remaining entries.
REQ-025 Redirect in DRAIN SHALL reload fetch_pc/resp_pc; drop_cnt SHALL track all still-outstanding requests.
REQ-026 Response while imem has no outstanding request is illegal; behaviour unspecified, assertion in bench.
REQ-027 Minimum latency: request accepted cycle N, response cycle N+1, out_valid cycle N+2.

Reset
REQ-028 While rst=0: state IDLE, fetch_pc = resp_pc = RESET_PC, outstanding = drop_cnt = 0, queue empty, imem_req_valid = 0, out_valid = 0, out_inst = 0, out_pc_plus_4 = 0.
REQ-029 Reset mid-operation SHALL abandon all in-flight requests immediately; memory model also reset.

Structure
REQ-030 FQ default depth, RESET_PC default and state encodings SHALL live in defines.v alongside `ADDR_LEN/`INSTR_LEN.
REQ-031 Queue SHALL be one sub-module, fetch_queue (sync FIFO with flush, count output).
REQ-032 Total RTL 120-400 lines; no combinational path from imem_resp_* to out_*.

Verification
REQ-033 Reset release, 1-cycle memory, out_ready=1 -> requests 0x0,0x4,0x8...; out_pc_plus_4 = 0x4,0x8,... one per cycle steady state.
REQ-034 out_ready=0 for 10 cycles -> exactly 4 requests issued, queue full, out_* stable; release -> 4 entries in order, fetch resumes.
REQ-035 3 outstanding at 3-cycle latency, redirect_pc=0x100 -> 3 responses dropped, next out_pc_plus_4 = 0x104.
REQ-036 Redirect same cycle as response and out handshake -> response dropped, handshake counted once, queue empty next cycle.
REQ-037 redirect_pc=32'hFFFFFFFC -> requests 0xFFFFFFFC then 0x0; out_pc_plus_4 = 0x0 then 0x4.
REQ-038 rst=0 asserted while 2 requests outstanding -> all outputs at reset values same cycle; after release first request 0x0.
